// File: rtl/tia_audio_pkg.sv
// Shared constants and helpers for the TIA-style audio voices.
// Mode codes, poly seeds/taps and divider limits live here.
package tia_audio_pkg;

  typedef enum logic [1:0] {
    SEL_AUDC = 2'd0,
    SEL_AUDF = 2'd1,
    SEL_AUDV = 2'd2,
    SEL_RSVD = 2'd3
  } sel_e;

  localparam logic [3:0] AUDC_SET0     = 4'h0;
  localparam logic [3:0] AUDC_POLY4    = 4'h1;
  localparam logic [3:0] AUDC_DIV31_P4 = 4'h2;
  localparam logic [3:0] AUDC_P5_P4    = 4'h3;
  localparam logic [3:0] AUDC_TONE     = 4'h4;
  localparam logic [3:0] AUDC_TONE_B   = 4'h5;
  localparam logic [3:0] AUDC_DIV31    = 4'h6;
  localparam logic [3:0] AUDC_POLY5    = 4'h7;
  localparam logic [3:0] AUDC_POLY9    = 4'h8;
  localparam logic [3:0] AUDC_POLY5_B  = 4'h9;
  localparam logic [3:0] AUDC_DIV31_B  = 4'hA;
  localparam logic [3:0] AUDC_SET1     = 4'hB;
  localparam logic [3:0] AUDC_TONE3    = 4'hC;
  localparam logic [3:0] AUDC_TONE3_B  = 4'hD;
  localparam logic [3:0] AUDC_DIV93    = 4'hE;
  localparam logic [3:0] AUDC_P5_DIV3  = 4'hF;

  localparam logic [3:0] POLY4_SEED = 4'hF;
  localparam logic [4:0] POLY5_SEED = 5'h1F;
  localparam logic [8:0] POLY9_SEED = 9'h1FF;
  localparam int P4_TAP = 1;
  localparam int P5_TAP = 2;
  localparam int P9_TAP = 4;

  localparam logic [4:0] DIV31_HI  = 5'd18;
  localparam logic [4:0] DIV31_MAX = 5'd30;
  localparam logic [1:0] DIV3_MAX  = 2'd2;

  function automatic logic [3:0] adv4(input logic [3:0] p);
    return {p[0] ^ p[P4_TAP], p[3:1]};
  endfunction

  function automatic logic [4:0] adv5(input logic [4:0] p);
    return {p[0] ^ p[P5_TAP], p[4:1]};
  endfunction

  function automatic logic [8:0] adv9(input logic [8:0] p);
    return {p[0] ^ p[P9_TAP], p[8:1]};
  endfunction

  function automatic logic [4:0] inc31(input logic [4:0] d);
    return (d == DIV31_MAX) ? 5'd0 : d + 5'd1;
  endfunction

  function automatic logic [1:0] inc3(input logic [1:0] d);
    return (d == DIV3_MAX) ? 2'd0 : d + 2'd1;
  endfunction

endpackage

// File: rtl/tia_audio_voice.sv
// One audio voice: frequency divider, poly counters, mode decode.
// The sample register loads on every audio tick.
module tia_audio_voice
  import tia_audio_pkg::*;
#(
  parameter int FREQ_W = 5,
  parameter int VOL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [3:0]        audc,
  input  logic [FREQ_W-1:0] audf,
  input  logic [VOL_W-1:0]  audv,
  output logic [VOL_W-1:0]  sample_d,
  output logic [VOL_W-1:0]  sample
);

  logic [FREQ_W-1:0] div, div_n;
  logic [1:0] d3, d3_n;
  logic [4:0] d31, d31_n;
  logic tone, tone_n;
  logic [3:0] p4, p4_n;
  logic [4:0] p5, p5_n;
  logic [8:0] p9, p9_n;
  logic step, bit_n;

  always_comb begin
    step   = (div == audf);
    div_n  = step ? '0 : div + 1'b1;
    d3_n   = d3;
    d31_n  = d31;
    tone_n = tone;
    p4_n   = p4;
    p5_n   = p5;
    p9_n   = p9;
    if (step) begin
      unique case (audc)
        AUDC_POLY4: p4_n = adv4(p4);
        AUDC_DIV31_P4: begin
          d31_n = inc31(d31);
          if (d31_n == 5'd0 || d31_n == DIV31_HI)
            p4_n = adv4(p4);
        end
        AUDC_P5_P4: begin
          p5_n = adv5(p5);
          if (p5_n[0])
            p4_n = adv4(p4);
        end
        AUDC_TONE, AUDC_TONE_B: tone_n = ~tone;
        AUDC_DIV31, AUDC_DIV31_B: d31_n = inc31(d31);
        AUDC_POLY5, AUDC_POLY5_B: p5_n = adv5(p5);
        AUDC_POLY9: p9_n = adv9(p9);
        AUDC_TONE3, AUDC_TONE3_B: begin
          d3_n = inc3(d3);
          if (d3_n == 2'd0)
            tone_n = ~tone;
        end
        AUDC_DIV93: begin
          d3_n = inc3(d3);
          if (d3_n == 2'd0)
            d31_n = inc31(d31);
        end
        AUDC_P5_DIV3: begin
          d3_n = inc3(d3);
          if (d3_n == 2'd0)
            p5_n = adv5(p5);
        end
        default: ;
      endcase
    end
  end

  // Output bit is taken from post-step state so the tick's step is audible.
  always_comb begin
    unique case (audc)
      AUDC_POLY4, AUDC_DIV31_P4, AUDC_P5_P4:
        bit_n = p4_n[0];
      AUDC_TONE, AUDC_TONE_B, AUDC_TONE3, AUDC_TONE3_B:
        bit_n = tone_n;
      AUDC_DIV31, AUDC_DIV31_B, AUDC_DIV93:
        bit_n = (d31_n < DIV31_HI);
      AUDC_POLY5, AUDC_POLY5_B, AUDC_P5_DIV3:
        bit_n = p5_n[0];
      AUDC_POLY9:
        bit_n = p9_n[0];
      default:
        bit_n = 1'b1;
    endcase
  end

  assign sample_d = bit_n ? audv : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      d3     <= '0;
      d31    <= '0;
      tone   <= 1'b0;
      p4     <= POLY4_SEED;
      p5     <= POLY5_SEED;
      p9     <= POLY9_SEED;
      sample <= '0;
    end else if (tick) begin
      div    <= div_n;
      d3     <= d3_n;
      d31    <= d31_n;
      tone   <= tone_n;
      p4     <= p4_n;
      p5     <= p5_n;
      p9     <= p9_n;
      sample <= sample_d;
    end
  end

endmodule

// File: rtl/tia_audio_voices.sv
// Multi-voice TIA-style audio: register file, NUM_CH voices, mixer.
// mix_out and ch_out update together, one cycle after audio_tick.
module tia_audio_voices
  import tia_audio_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int FREQ_W = 5,
  parameter int VOL_W  = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MIX_W = VOL_W + $clog2(NUM_CH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    audio_tick,
  input  logic                    wr_en,
  input  logic [CH_W+1:0]         wr_addr,
  input  logic [7:0]              wr_data,
  output logic [NUM_CH*VOL_W-1:0] ch_out,
  output logic [MIX_W-1:0]        mix_out,
  output logic                    sample_valid
);

  logic [3:0]        audc_r [NUM_CH];
  logic [FREQ_W-1:0] audf_r [NUM_CH];
  logic [VOL_W-1:0]  audv_r [NUM_CH];
  logic [VOL_W-1:0]  smp_d  [NUM_CH];
  logic [MIX_W-1:0]  mix_d;

  logic [CH_W-1:0] wr_ch;
  sel_e            wr_sel;
  logic            wr_ok;
  logic            unused_wr;

  assign wr_ch     = wr_addr[CH_W+1:2];
  assign wr_sel    = sel_e'(wr_addr[1:0]);
  assign wr_ok     = wr_en && (int'(wr_ch) < NUM_CH) &&
                     (wr_sel != SEL_RSVD);
  assign unused_wr = ^wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        audc_r[i] <= '0;
        audf_r[i] <= '0;
        audv_r[i] <= '0;
      end
    end else if (wr_ok) begin
      unique case (wr_sel)
        SEL_AUDC: audc_r[wr_ch] <= wr_data[3:0];
        SEL_AUDF: audf_r[wr_ch] <= wr_data[FREQ_W-1:0];
        SEL_AUDV: audv_r[wr_ch] <= wr_data[VOL_W-1:0];
        SEL_RSVD: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
    tia_audio_voice #(
      .FREQ_W(FREQ_W),
      .VOL_W (VOL_W)
    ) u_voice (
      .clk     (clk),
      .rst     (rst),
      .tick    (audio_tick),
      .audc    (audc_r[g]),
      .audf    (audf_r[g]),
      .audv    (audv_r[g]),
      .sample_d(smp_d[g]),
      .sample  (ch_out[g*VOL_W +: VOL_W])
    );
  end

  // Sum the voices' next samples so the mix lands with ch_out.
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      mix_d = mix_d + MIX_W'(smp_d[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_out      <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= audio_tick;
      if (audio_tick)
        mix_out <= mix_d;
    end
  end

endmodule
